// File: rtl/mat_pkg.sv
// Shared constants and FSM state type for the matrix frame loader.
package mat_pkg;
  localparam int unsigned W     = 16;
  localparam int unsigned N     = 3;
  localparam int unsigned ELEMS = N * N;
  localparam int unsigned FRAME = 2 * N * N;

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    RUN
  } state_t;
endpackage

// File: rtl/frame_counter.sv
// Counts accepted words within a frame, wrapping after the last word of the frame.
module frame_counter
  import mat_pkg::*;
#(
  parameter int unsigned LEN = mat_pkg::FRAME,
  parameter int unsigned CW  = $clog2(LEN)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_inc,
  input  logic          i_clr,
  output logic [CW-1:0] o_count
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_count <= '0;
    end else if (i_clr) begin
      o_count <= '0;
    end else if (i_inc) begin
      o_count <= (o_count == CW'(LEN - 1)) ? '0 : o_count + 1'b1;
    end
  end

endmodule

// File: rtl/mat_loader.sv
// Assembles a streamed frame of A then B elements into flat matrices and hands them to the control unit.
module mat_loader
  import mat_pkg::*;
#(
  parameter int unsigned W = mat_pkg::W,
  parameter int unsigned N = mat_pkg::N
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [W-1:0]     i_data,
  input  logic             i_last,
  input  logic             i_mode,
  output logic             o_ready,
  output logic [W*N*N-1:0] o_A,
  output logic [W*N*N-1:0] o_B,
  output logic             o_mode,
  output logic             o_en,
  input  logic             i_done,
  output logic             o_busy,
  output logic             o_err,
  input  logic             i_err_clr
);

  localparam int unsigned NE = N * N;
  localparam int unsigned NF = 2 * NE;
  localparam int unsigned CW = $clog2(NF);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   slot;
  int unsigned     slot_lsb;
  logic            accept;
  logic            at_a_end;
  logic            at_final;
  logic            err_evt;
  logic            run_done;

  assign accept   = i_valid && o_ready;
  assign at_a_end = (cnt == CW'(NE - 1));
  assign at_final = (cnt == CW'(NF - 1));
  // A framing error is i_last on the wrong word, or its absence on the final word.
  assign err_evt  = accept && (i_last != at_final);
  assign run_done = (state == RUN) && i_done;

  frame_counter #(
    .LEN (NF),
    .CW  (CW)
  ) u_frame_counter (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   (accept),
    .i_clr   (err_evt || run_done),
    .o_count (cnt)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= LOAD_A;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every signal driven in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD_A: if (accept) state_nxt = err_evt ? LOAD_A : (at_a_end ? LOAD_B : LOAD_A);
      LOAD_B: if (accept) state_nxt = err_evt ? LOAD_A : (at_final ? RUN : LOAD_B);
      RUN:    if (i_done) state_nxt = LOAD_A;
      default: state_nxt = LOAD_A;
    endcase
  end

  always_comb begin
    o_ready = (state != RUN);
    o_en    = (state == RUN);
    o_busy  = (state == RUN);
  end

  // Element (0,0) lands in the most significant word of each flat matrix.
  always_comb begin
    slot     = (state == LOAD_B) ? cnt - CW'(NE) : cnt;
    slot_lsb = (NE - 1 - int'(slot)) * W;
  end

  // NOTE: the matrix registers are reset because downstream logic observes them as zero after reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_A    <= '0;
      o_B    <= '0;
      o_mode <= 1'b0;
    end else if (accept) begin
      if (cnt == '0) o_mode <= i_mode;
      if (state == LOAD_A) o_A[slot_lsb +: W] <= i_data;
      else                 o_B[slot_lsb +: W] <= i_data;
    end
  end

  // A new error outranks a clear arriving on the same edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_err <= 1'b0;
    end else if (err_evt) begin
      o_err <= 1'b1;
    end else if (i_err_clr) begin
      o_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mat_loader.sv
// Directed, table-driven bench for mat_loader with hand-computed expected matrices.
module tb_mat_loader;
  import mat_pkg::*;

  localparam int unsigned MW = W * ELEMS;

  localparam logic [MW-1:0] ONE_COL = 144'h0000_0000_3c00_0000_0000_3c00_0000_0000_3c00;
  localparam logic [MW-1:0] SEQ_A   = 144'h0001_0002_0003_0004_0005_0006_0007_0008_0009;
  localparam logic [MW-1:0] SEQ_B   = 144'h0011_0012_0013_0014_0015_0016_0017_0018_0019;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_valid;
  logic [W-1:0]  i_data;
  logic          i_last;
  logic          i_mode;
  logic          o_ready;
  logic [MW-1:0] o_A;
  logic [MW-1:0] o_B;
  logic          o_mode;
  logic          o_en;
  logic          i_done;
  logic          o_busy;
  logic          o_err;
  logic          i_err_clr;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
    logic         mode;
    logic         exp_ready;
    logic         exp_en;
  } vec_t;

  vec_t tbl [FRAME];

  mat_loader #(.W(W), .N(N)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_valid   (i_valid),
    .i_data    (i_data),
    .i_last    (i_last),
    .i_mode    (i_mode),
    .o_ready   (o_ready),
    .o_A       (o_A),
    .o_B       (o_B),
    .o_mode    (o_mode),
    .o_en      (o_en),
    .i_done    (i_done),
    .o_busy    (o_busy),
    .o_err     (o_err),
    .i_err_clr (i_err_clr)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] d, input logic l, input logic m);
    i_valid = 1'b1;
    i_data  = d;
    i_last  = l;
    i_mode  = m;
    step();
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  // Idle cycles present junk that must be ignored because i_valid is low.
  task automatic idle(input int n);
    i_valid = 1'b0;
    i_data  = 16'hdead;
    i_last  = 1'b1;
    for (int i = 0; i < n; i++) step();
    i_last  = 1'b0;
  endtask

  task automatic send_seq_frame(input logic m);
    for (int k = 0; k < FRAME; k++) begin
      send_word((k < ELEMS) ? 16'(k + 1) : 16'(16'h10 + k - ELEMS + 1),
                (k == FRAME - 1), (k == 0) ? m : ~m);
    end
  endtask

  task automatic finish_run();
    i_done = 1'b1;
    step();
    i_done = 1'b0;
    check("done_en_low", o_en, 1'b0);
    check("done_ready_high", o_ready, 1'b1);
  endtask

  initial begin
    logic en_seen;

    i_rst = 1'b1; i_valid = 1'b0; i_data = '0; i_last = 1'b0;
    i_mode = 1'b0; i_done = 1'b0; i_err_clr = 1'b0;
    #12;
    check("rst_ready", o_ready, 1'b1);
    check("rst_en", o_en, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_err", o_err, 1'b0);
    check("rst_A", o_A, '0);
    check("rst_B", o_B, '0);
    check("rst_mode", o_mode, 1'b0);
    @(posedge i_clk);
    #1 i_rst = 1'b0;

    for (int k = 0; k < FRAME; k++) begin
      tbl[k].data      = (k % 3 == 2) ? 16'h3c00 : 16'h0000;
      tbl[k].last      = (k == FRAME - 1);
      tbl[k].mode      = (k == 0);
      tbl[k].exp_ready = (k != FRAME - 1);
      tbl[k].exp_en    = (k == FRAME - 1);
    end

    // Continuous-valid frame driven from the vector table.
    for (int k = 0; k < FRAME; k++) begin
      send_word(tbl[k].data, tbl[k].last, tbl[k].mode);
      check($sformatf("f1_ready_w%0d", k + 1), o_ready, tbl[k].exp_ready);
      check($sformatf("f1_en_w%0d", k + 1), o_en, tbl[k].exp_en);
      check($sformatf("f1_busy_w%0d", k + 1), o_busy, tbl[k].exp_en);
    end
    check("f1_A", o_A, ONE_COL);
    check("f1_B", o_B, ONE_COL);
    check("f1_mode", o_mode, 1'b1);
    check("f1_err", o_err, 1'b0);

    // Words offered during RUN must not be accepted.
    send_word(16'hffff, 1'b1, 1'b0);
    check("run_hold_A", o_A, ONE_COL);
    check("run_hold_B", o_B, ONE_COL);
    check("run_hold_err", o_err, 1'b0);
    check("run_hold_ready", o_ready, 1'b0);
    finish_run();
    check("done_busy_low", o_busy, 1'b0);

    // Same frame with valid toggling every cycle.
    for (int k = 0; k < FRAME; k++) begin
      send_word(tbl[k].data, tbl[k].last, 1'b0);
      if (k < FRAME - 1) idle(1);
    end
    check("f2_A", o_A, ONE_COL);
    check("f2_B", o_B, ONE_COL);
    check("f2_mode", o_mode, 1'b0);
    for (int c = 0; c < 10; c++) begin
      step();
      check($sformatf("f2_en_hold_c%0d", c), o_en, 1'b1);
    end
    finish_run();

    // i_last on word 5 is a framing error.
    for (int k = 0; k < 4; k++) send_word(16'h7000, 1'b0, 1'b1);
    send_word(16'h7000, 1'b1, 1'b1);
    check("early_last_err", o_err, 1'b1);
    check("early_last_ready", o_ready, 1'b1);
    check("early_last_en", o_en, 1'b0);

    // Clean frame follows from slot 0; i_done mid-load must be ignored.
    for (int k = 0; k < FRAME; k++) begin
      send_word((k < ELEMS) ? 16'(k + 1) : 16'(16'h10 + k - ELEMS + 1),
                (k == FRAME - 1), (k == 0) ? 1'b0 : 1'b1);
      if (k == 3) begin
        i_done = 1'b1;
        step();
        i_done = 1'b0;
      end
    end
    check("f3_A", o_A, SEQ_A);
    check("f3_B", o_B, SEQ_B);
    check("f3_mode", o_mode, 1'b0);
    check("f3_en", o_en, 1'b1);
    check("f3_err_sticky", o_err, 1'b1);
    finish_run();
    i_err_clr = 1'b1;
    step();
    i_err_clr = 1'b0;
    check("err_clr", o_err, 1'b0);

    // New error and clear on the same edge: the error wins.
    i_err_clr = 1'b1;
    send_word(16'h1234, 1'b1, 1'b0);
    i_err_clr = 1'b0;
    check("err_beats_clr", o_err, 1'b1);
    i_err_clr = 1'b1;
    step();
    i_err_clr = 1'b0;
    check("err_clr2", o_err, 1'b0);

    // Full-length frame without i_last.
    en_seen = 1'b0;
    for (int k = 0; k < FRAME; k++) begin
      send_word(16'(16'h0100 + k), 1'b0, 1'b0);
      en_seen = en_seen | o_en;
    end
    check("nolast_err", o_err, 1'b1);
    check("nolast_en_never", en_seen, 1'b0);
    check("nolast_ready", o_ready, 1'b1);

    // Reset while word 12 is presented.
    for (int k = 0; k < 11; k++) send_word(16'(16'h0200 + k), 1'b0, 1'b1);
    i_valid = 1'b1;
    i_data  = 16'h0299;
    #2 i_rst = 1'b1;
    #1;
    check("mid_rst_A", o_A, '0);
    check("mid_rst_B", o_B, '0);
    check("mid_rst_mode", o_mode, 1'b0);
    check("mid_rst_err", o_err, 1'b0);
    check("mid_rst_en", o_en, 1'b0);
    check("mid_rst_ready", o_ready, 1'b1);
    i_valid = 1'b0;
    step();
    check("mid_rst_en_edge", o_en, 1'b0);
    i_rst = 1'b0;
    step();
    send_seq_frame(1'b1);
    check("f4_A", o_A, SEQ_A);
    check("f4_B", o_B, SEQ_B);
    check("f4_mode", o_mode, 1'b1);
    check("f4_en", o_en, 1'b1);
    check("f4_err", o_err, 1'b0);
    finish_run();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mat_loader.md
MAT_LOADER -- requirements
Module: mat_loader

Interface
REQ-001 Parameter W, default 16, element width in bits (fp16 encoding, opaque to this block).
REQ-002 Parameter N, default 3, matrix dimension; each matrix holds N*N elements.
REQ-003 i_clk  in  1  single clock; all state on rising edge.
REQ-004 i_rst  in  1  reset, asynchronous, active-high.
REQ-005 i_valid  in  1  upstream word valid.
REQ-006 i_data  in  W  upstream element word.
REQ-007 i_last  in  1  marks final word of a frame.
REQ-008 i_mode  in  1  operation mode for the frame, sampled with the first accepted word.
REQ-009 o_ready  out  1  block can accept a word.
REQ-010 o_A  out  W*N*N  assembled A matrix, flat.
REQ-011 o_B  out  W*N*N  assembled B matrix, flat.
REQ-012 o_mode  out  1  latched frame mode, drives the control unit mode input.
REQ-013 o_en  out  1  enable to the control unit.
REQ-014 i_done  in  1  completion from the control unit.
REQ-015 o_busy  out  1  high while a loaded frame is being computed.
REQ-016 o_err  out  1  sticky framing error.
REQ-017 i_err_clr  in  1  clears o_err.

Function
REQ-018 A word is accepted on a rising edge when i_valid and o_ready are both high; no other word has effect.
REQ-019 A frame is exactly 2*N*N words: A elements row-major (k = 0..N*N-1), then B elements row-major.
REQ-020 Element k (row r, col c, k = r*N+c) occupies bits [(N*N-1-k)*W +: W], so element (0,0) is the MSB word.
REQ-021 FSM states: LOAD_A (reset state), LOAD_B, RUN.
REQ-022 LOAD_A: o_ready=1; accepted word written to o_A slot k; after slot N*N-1 -> LOAD_B.
REQ-023 LOAD_B: o_ready=1; accepted word written to o_B slot k; after slot N*N-1 with i_last=1 -> RUN.
REQ-024 The first accepted word of a frame latches i_mode into o_mode; o_mode holds until the next frame's first word.
REQ-025 RUN: o_ready=0, o_en=1, o_busy=1, o_A/o_B/o_mode held stable.
REQ-026 o_en and o_busy rise on the same edge that accepts the final B word (zero extra latency).
REQ-027 In RUN, i_done sampled high -> LOAD_A on that edge; o_en, o_busy fall and o_ready rises on that edge.
REQ-028 i_done outside RUN is ignored.
REQ-029 i_last=1 on any word other than word 2*N*N: o_err set, frame discarded, counter cleared, state LOAD_A on that edge.
REQ-030 Final B word accepted with i_last=0: o_err set, frame discarded, state LOAD_A, o_en stays 0.
REQ-031 Discarded frames leave o_A/o_B contents undefined-but-stable; next frame overwrites every slot.
REQ-032 i_err_clr clears o_err on the next edge; a simultaneous new error wins (o_err stays 1).
REQ-033 o_A/o_B words not yet written in a frame retain prior values.

Reset
REQ-034 On i_rst high, asynchronously: state LOAD_A, counter 0, o_A=0, o_B=0, o_mode=0, o_en=0, o_busy=0, o_err=0, o_ready=1 (o_ready combinational from state).
REQ-035 Reset mid-frame or mid-RUN abandons the frame; no partial o_en pulse.

Structure
REQ-036 Shared package mat_pkg holds W, N, ELEMS = N*N, FRAME = 2*N*N and the state enum.
REQ-037 One sub-module, frame_counter: counts accepted words 0..FRAME-1, wraps to 0, synchronous clear on error/done.

Verification
REQ-038 Reset asserted -> o_ready=1, o_en=0, o_busy=0, o_err=0, o_A=o_B=0.
REQ-039 18 words, i_valid continuous, A and B each row = {0x0000,0x0000,0x3c00}, i_last on word 18 -> o_A=o_B={0000,0000,3c00}x3, o_en=1 from the edge accepting word 18, o_ready=0.
REQ-040 Same frame with i_valid toggling every cycle -> identical o_A/o_B; i_done held low 10 cycles -> o_en held 1; i_done one cycle -> o_en=0, o_ready=1 on that edge.
REQ-041 i_last on word 5 -> o_err=1, state LOAD_A; following clean frame loads A slot 0 first and completes normally; i_err_clr -> o_err=0.
REQ-042 18 words with i_last=0 -> o_err=1, o_en never rises.
REQ-043 i_rst pulsed while word 12 is presented -> outputs zero immediately, no o_en; next frame loads correctly from A slot 0.
